pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the PC stall-hold input, the IF/ID hold and flush, the ID/EX bubble, and the EX/MEM and MEM/WB holds. It resolves three hazard sources in fixed priority: data-cache miss, load-use, then taken branch/jump. It also tracks run state from start_i and keeps saturating performance counters.

Parameters:
CNT_W, 16, width of each performance counter
REG_W, 5, register-index width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  core run enable (level)
id_rs_i  in  REG_W  rs index of instruction in ID
id_rt_i  in  REG_W  rt index of instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt as a source
ex_memread_i  in  1  instruction in EX is a load
ex_rt_i  in  REG_W  destination rt of the load in EX
id_redirect_i  in  1  taken branch or jump resolved in ID
mem_stall_i  in  1  data cache busy/miss (level, from cache)
pc_hold_o  out  1  to PC stallHold input
ifid_hold_o  out  1  IF/ID register keeps its value
ifid_flush_o  out  1  IF/ID loads a NOP
idex_bubble_o  out  1  ID/EX loads control zeros
exmem_hold_o  out  1  EX/MEM keeps its value
memwb_hold_o  out  1  MEM/WB keeps its value
running_o  out  1  state != BOOT
stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1 while not in BOOT
flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1
miss_cnt_o  out  CNT_W  cycles spent in MISS state

Behaviour:
- FSM states: BOOT, RUN, MISS. State and counters are registered. All *_hold/flush/bubble outputs are combinational from the current state and the current inputs, so they act in the same cycle as the hazard.
- Reset (rst_i=0, asynchronous): state=BOOT; all counters=0. Outputs in BOOT: pc_hold_o=ifid_hold_o=exmem_hold_o=memwb_hold_o=1; ifid_flush_o=idex_bubble_o=0; running_o=0.
- BOOT: all holds stay asserted. If start_i=1, next state is RUN. The first unheld cycle is the cycle after start_i is sampled high.
- RUN and MISS: if start_i=0, next state is BOOT and holds are asserted in that same cycle. This has priority over every other condition.
- RUN, mem_stall_i=1: assert all four holds; no flush, no bubble; next state MISS. Load-use and redirect are ignored this cycle.
- MISS: all four holds asserted while mem_stall_i=1. When mem_stall_i=0: holds released in that cycle (the cache presents data) and next state is RUN. miss_cnt_o increments every cycle in MISS.
- Load-use condition: ex_memread_i & (ex_rt_i!=0) & ((ex_rt_i==id_rs_i) | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- RUN, no mem stall, load-use true: pc_hold_o=1, ifid_hold_o=1, idex_bubble_o=1; EX/MEM and MEM/WB advance. id_redirect_i is ignored this cycle (no flush); the branch re-resolves next cycle.
- RUN, no mem stall, no load-use, id_redirect_i=1: ifid_flush_o=1; PC is not held (it loads the redirect target).
- RUN with no hazard: all outputs 0.
- ifid_hold_o and ifid_flush_o are never both 1. idex_bubble_o is never 1 while exmem_hold_o=1.
- Counters saturate at 2^CNT_W-1 and do not wrap. They are cleared only by reset and persist across BOOT transitions.
- stall_cnt_o counts RUN/MISS cycles with pc_hold_o=1. It does not count BOOT cycles.

Test Plan:
- Reset, then start_i=0 for 3 cycles, then start_i=1 → pc_hold_o=1 through the start edge cycle, 0 the next cycle; running_o rises with state RUN; stall_cnt_o=0.
- RUN: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for 1 cycle → pc_hold_o=ifid_hold_o=idex_bubble_o=1 for exactly 1 cycle; stall_cnt_o=1. Repeat with ex_rt_i=0 → no stall.
- RUN: id_redirect_i=1 alone → ifid_flush_o=1, pc_hold_o=0, flush_cnt_o=1. Same cycle with a load-use match → flush=0, bubble=1.
- RUN: mem_stall_i=1 for 4 cycles with a simultaneous load-use and redirect → all four holds=1 for 4 cycles, bubble=0, flush=0; miss_cnt_o=3; return to RUN when mem_stall_i=0.
- mem_stall_i held high, rst_i pulsed low mid-MISS → immediate BOOT outputs, counters=0; start_i=0 in RUN → BOOT next cycle, holds=1 same cycle.
- CNT_W=4, 20 consecutive load-use cycles → stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It resolves three
//   hazard sources in fixed priority (data-cache miss, load-use, then taken
//   branch/jump), tracks core run state from start, and keeps saturating
//   performance counters.
//
//   State | meaning
//   BOOT  | core not started; every pipeline register held
//   RUN   | normal execution; hazards resolved combinationally each cycle
//   MISS  | waiting on the data cache; held until mem_stall drops
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   start_i             core run enable (level)
//   id_rs_i, id_rt_i    source register indices of the instruction in ID
//   id_uses_rt_i        ID instruction reads rt as a source
//   ex_memread_i        instruction in EX is a load
//   ex_rt_i             destination register of the load in EX
//   id_redirect_i       taken branch/jump resolved in ID
//   mem_stall_i         data cache busy/miss (level)
//   pc_hold_o           PC stall-hold
//   ifid_hold_o         IF/ID keeps its value
//   ifid_flush_o        IF/ID loads a NOP
//   idex_bubble_o       ID/EX loads control zeros
//   exmem_hold_o        EX/MEM keeps its value
//   memwb_hold_o        MEM/WB keeps its value
//   running_o           high whenever the state is not BOOT
//   stall_cnt_o         RUN/MISS cycles with pc_hold_o asserted (saturating)
//   flush_cnt_o         cycles with ifid_flush_o asserted (saturating)
//   miss_cnt_o          cycles spent in MISS (saturating)

module pipe_stall_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_redirect_i,
  input  logic             mem_stall_i,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_hold_o,
  output logic             memwb_hold_o,
  output logic             running_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;

  logic load_use;
  logic rs_match;
  logic rt_match;

  logic stall_inc;
  logic flush_inc;
  logic miss_inc;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rs_match = (ex_rt_i == id_rs_i);
  assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);
  assign load_use = ex_memread_i && (ex_rt_i != '0) && (rs_match || rt_match);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Hold/flush/bubble are decoded from the current state and the current
  // hazard inputs so they take effect in the same cycle as the hazard.
  always_comb begin
    state_nxt     = state;
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_hold_o  = 1'b0;
    memwb_hold_o  = 1'b0;

    case (state)
      BOOT: begin
        pc_hold_o    = 1'b1;
        ifid_hold_o  = 1'b1;
        exmem_hold_o = 1'b1;
        memwb_hold_o = 1'b1;
        if (start_i) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (!start_i) begin
          // Dropping start freezes the pipe immediately, ahead of any hazard.
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          exmem_hold_o = 1'b1;
          memwb_hold_o = 1'b1;
          state_nxt    = BOOT;
        end else if (mem_stall_i) begin
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          exmem_hold_o = 1'b1;
          memwb_hold_o = 1'b1;
          state_nxt    = MISS;
        end else if (load_use) begin
          // The redirect is dropped here; the branch re-resolves next cycle
          // once the load result is forwardable.
          pc_hold_o     = 1'b1;
          ifid_hold_o   = 1'b1;
          idex_bubble_o = 1'b1;
        end else if (id_redirect_i) begin
          ifid_flush_o = 1'b1;
        end
      end

      MISS: begin
        if (!start_i) begin
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          exmem_hold_o = 1'b1;
          memwb_hold_o = 1'b1;
          state_nxt    = BOOT;
        end else if (mem_stall_i) begin
          pc_hold_o    = 1'b1;
          ifid_hold_o  = 1'b1;
          exmem_hold_o = 1'b1;
          memwb_hold_o = 1'b1;
        end else begin
          // Cache presents data this cycle; release everything.
          state_nxt = RUN;
        end
      end

      default: begin
        pc_hold_o    = 1'b1;
        ifid_hold_o  = 1'b1;
        exmem_hold_o = 1'b1;
        memwb_hold_o = 1'b1;
        state_nxt    = BOOT;
      end
    endcase
  end

  assign running_o = (state != BOOT);

  assign stall_inc = running_o && pc_hold_o;
  assign flush_inc = ifid_flush_o;
  assign miss_inc  = (state == MISS);

  // Counters are cleared only by reset and persist across BOOT transitions.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_inc && (stall_cnt_o != CNT_MAX)) begin
      stall_cnt_o <= stall_cnt_o + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_cnt_o <= '0;
    end else if (flush_inc && (flush_cnt_o != CNT_MAX)) begin
      flush_cnt_o <= flush_cnt_o + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      miss_cnt_o <= '0;
    end else if (miss_inc && (miss_cnt_o != CNT_MAX)) begin
      miss_cnt_o <= miss_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
//   Scoreboard bench for pipe_stall_ctrl. Two instances share the stimulus:
//   one with 16-bit counters and one with 4-bit counters so saturation is
//   reachable. The driver computes the expected response from a rule-level
//   reference model and queues it; a monitor pops and compares on each
//   falling edge.

module tb_pipe_stall_ctrl;

  localparam int REG_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             id_redirect;
  logic             mem_stall;

  logic        pc_hold_a, ifid_hold_a, ifid_flush_a, idex_bubble_a;
  logic        exmem_hold_a, memwb_hold_a, running_a;
  logic [15:0] stall_cnt_a, flush_cnt_a, miss_cnt_a;

  logic        pc_hold_b, ifid_hold_b, ifid_flush_b, idex_bubble_b;
  logic        exmem_hold_b, memwb_hold_b, running_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b, miss_cnt_b;

  pipe_stall_ctrl #(.CNT_W(16), .REG_W(REG_W)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
    .id_redirect_i(id_redirect), .mem_stall_i(mem_stall),
    .pc_hold_o(pc_hold_a), .ifid_hold_o(ifid_hold_a),
    .ifid_flush_o(ifid_flush_a), .idex_bubble_o(idex_bubble_a),
    .exmem_hold_o(exmem_hold_a), .memwb_hold_o(memwb_hold_a),
    .running_o(running_a), .stall_cnt_o(stall_cnt_a),
    .flush_cnt_o(flush_cnt_a), .miss_cnt_o(miss_cnt_a)
  );

  pipe_stall_ctrl #(.CNT_W(4), .REG_W(REG_W)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
    .id_redirect_i(id_redirect), .mem_stall_i(mem_stall),
    .pc_hold_o(pc_hold_b), .ifid_hold_o(ifid_hold_b),
    .ifid_flush_o(ifid_flush_b), .idex_bubble_o(idex_bubble_b),
    .exmem_hold_o(exmem_hold_b), .memwb_hold_o(memwb_hold_b),
    .running_o(running_b), .stall_cnt_o(stall_cnt_b),
    .flush_cnt_o(flush_cnt_b), .miss_cnt_o(miss_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed response: {run, pc, ifid_hold, flush, bubble, exmem, memwb,
  //                   stall16, flush16, miss16, stall4, flush4, miss4}
  typedef logic [66:0] resp_t;

  resp_t exp_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  // Reference model: run phase as plain ints, counts unbounded.
  int m_phase;   // 0 = stopped, 1 = running, 2 = waiting on cache
  int m_stall, m_flush, m_miss;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic step(input string tag, input bit r, input bit st, input bit ms,
                      input bit mr, input bit rd, input bit ur,
                      input int rs, input int rt, input int xrt);
    bit lu;
    bit hold_all, pc, ih, fl, bb;
    int next_phase;
    resp_t e;
    @(posedge clk);
    #1;
    rst = r; start = st; mem_stall = ms; ex_memread = mr; id_redirect = rd;
    id_uses_rt = ur; id_rs = REG_W'(rs); id_rt = REG_W'(rt); ex_rt = REG_W'(xrt);

    if (!r) begin
      m_phase = 0; m_stall = 0; m_flush = 0; m_miss = 0;
    end

    lu = mr && (xrt != 0) && ((xrt == rs) || (ur && xrt == rt));
    hold_all = 0; pc = 0; ih = 0; fl = 0; bb = 0;
    next_phase = m_phase;
    if (m_phase == 0) begin
      hold_all = 1;
      if (st) next_phase = 1;
    end else if (!st) begin
      hold_all = 1; next_phase = 0;
    end else if (m_phase == 1) begin
      if (ms) begin
        hold_all = 1; next_phase = 2;
      end else if (lu) begin
        pc = 1; ih = 1; bb = 1;
      end else if (rd) begin
        fl = 1;
      end
    end else begin
      if (ms) hold_all = 1;
      else next_phase = 1;
    end
    if (hold_all) begin pc = 1; ih = 1; end

    e = {(m_phase != 0), pc, ih, fl, bb, hold_all, hold_all,
         16'(sat(m_stall, 65535)), 16'(sat(m_flush, 65535)), 16'(sat(m_miss, 65535)),
         4'(sat(m_stall, 15)), 4'(sat(m_flush, 15)), 4'(sat(m_miss, 15))};
    exp_q.push_back(e);
    tag_q.push_back(tag);

    if (r) begin
      if (m_phase != 0 && pc) m_stall++;
      if (fl) m_flush++;
      if (m_phase == 2) m_miss++;
      m_phase = next_phase;
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    resp_t a;
    resp_t e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {running_a, pc_hold_a, ifid_hold_a, ifid_flush_a, idex_bubble_a,
           exmem_hold_a, memwb_hold_a, stall_cnt_a, flush_cnt_a, miss_cnt_a,
           stall_cnt_b, flush_cnt_b, miss_cnt_b};
      n_chk++;
      if (a === e && pc_hold_b === pc_hold_a && ifid_hold_b === ifid_hold_a &&
          ifid_flush_b === ifid_flush_a && idex_bubble_b === idex_bubble_a &&
          exmem_hold_b === exmem_hold_a && memwb_hold_b === memwb_hold_a &&
          running_b === running_a)
        n_pass++;
      else
        $display("FAIL %s @%0t: got %h (b ctl %b%b%b%b%b%b%b) expected %h", t, $time, a,
                 running_b, pc_hold_b, ifid_hold_b, ifid_flush_b, idex_bubble_b,
                 exmem_hold_b, memwb_hold_b, e);
    end
  end

  initial begin
    int wait_cyc;
    rst = 0; start = 0; mem_stall = 0; ex_memread = 0; id_redirect = 0;
    id_uses_rt = 0; id_rs = '0; id_rt = '0; ex_rt = '0;
    m_phase = 0; m_stall = 0; m_flush = 0; m_miss = 0;

    // Reset, boot with start low, then start.
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("boot_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("start_edge", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("run_first", 2);

    // Load-use on rs, then a load to r0 that must not stall.
    step("load_use_rs", 1, 1, 0, 1, 0, 0, 8, 3, 8);
    idle("after_lu", 1);
    step("load_r0", 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("load_use_rt", 1, 1, 0, 1, 0, 1, 2, 9, 9);
    step("rt_unused", 1, 1, 0, 1, 0, 0, 2, 9, 9);

    // Redirect alone, then redirect masked by load-use.
    step("redirect", 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step("redir_lu", 1, 1, 0, 1, 1, 0, 8, 0, 8);
    idle("after_redir", 1);

    // Cache miss for 4 cycles with load-use and redirect present.
    for (int i = 0; i < 4; i++) step("miss", 1, 1, 1, 1, 1, 0, 8, 0, 8);
    step("miss_release", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("after_miss", 2);

    // Saturation of the narrow stall counter.
    for (int i = 0; i < 20; i++) step("lu_sat", 1, 1, 0, 1, 0, 0, 5, 0, 5);
    idle("after_sat", 1);

    // Reset pulsed while a miss is pending.
    step("miss_pre", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("miss_pre", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("rst_mid_miss", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step("post_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("run_again", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("stop", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stopped", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("restart", 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with small register range to make matches likely.
    for (int i = 0; i < 3000; i++) begin
      step("random",
           ($urandom_range(0, 299) != 0),
           ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
